uart_boot_loader: RTL

// - Receives a program image over uart_rx and writes it into the Gowin_SP instruction BSRAM.
// - Receive-side counterpart of the UART transmit path; replaces the fixed boot_data table in top.
// - Holds the CPU in boot while loading; releases it (boot_mode=0) after a checksum-verified frame.

---
 rtl/boot_pkg.sv | 23 ++
 rtl/uart_rx_byte.sv | 106 ++++++++++
 rtl/uart_boot_loader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and frame-format constants for the UART boot loader.
// Frame on the wire: SYNC_BYTE, LEN (word count N, 0..255), N x {hi, lo}, SUM.
// SUM is the 8-bit modulo sum of LEN and every data byte; SYNC is not summed.
package boot_pkg;

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_LEN   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_SUM   = 3'd5,
        S_DONE  = 3'd6
    } boot_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Running checksum update; wraps modulo 256 by width.
    function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, start-bit glitch rejection,
// mid-bit sampling at DIV clock spacing, stop-bit check.
// rx_valid / frame_err are one-clock pulses; rx_data holds the last good byte.
module uart_rx_byte #(
    parameter int DIV = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic [1:0] rx_state
);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

    rx_state_t        state, state_nx;
    logic             rx_meta, rx_s, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             fall;
    logic             tick;

    assign fall     = rx_prev & ~rx_s;
    assign tick     = ((state == R_START) && (cnt == HALF_M1)) ||
                      (((state == R_DATA) || (state == R_STOP)) && (cnt == FULL_M1));
    assign rx_state = state;

    // Synchronise the asynchronous line and keep one extra stage for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= R_IDLE;
        else     state <= state_nx;
    end

    // Receiver next-state: a start bit must still be low at its midpoint.
    always_comb begin
        state_nx = state;
        unique case (state)
            R_IDLE:  if (fall) state_nx = R_START;
            R_START: if (tick) state_nx = rx_s ? R_IDLE : R_DATA;
            R_DATA:  if (tick && (bit_idx == 3'd7)) state_nx = R_STOP;
            R_STOP:  if (tick) state_nx = R_IDLE;
            default: state_nx = R_IDLE;
        endcase
    end

    // Bit timer, shifter and result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'd0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if ((state == R_IDLE) || tick) cnt <= '0;
            else                           cnt <= cnt + 1'b1;
            if (tick) begin
                unique case (state)
                    R_START: bit_idx <= 3'd0;
                    R_DATA: begin
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                    R_STOP: begin
                        if (rx_s) begin
                            rx_valid <= 1'b1;
                            rx_data  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a checksummed program image over UART and writes it word by word
// into the instruction BSRAM, holding the CPU in boot until a frame verifies.
// Handshake: the byte receiver offers rx_valid for one clock with no ready;
// the loader consumes every byte it is offered in the cycle it appears.
module uart_boot_loader #(
    parameter int         CLK_HZ    = 27_000_000,
    parameter int         BAUD      = 115_200,
    parameter int         ADDR_W    = 11,
    parameter int         TIMEOUT   = 2_700_000,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              boot_mode,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              load_done,
    output logic              load_err,
    output logic [7:0]        word_cnt,
    output logic [2:0]        fsm_state,
    output logic [1:0]        rx_state
);

    import boot_pkg::*;

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    boot_state_t state, state_nx;
    logic        rx_valid, frame_err;
    logic [7:0]  rx_data;
    logic [7:0]  n_len, sum, hi_q, lo_q;
    logic [TO_W-1:0] idle_cnt;
    logic        in_frame, timeout, abort, sync_seen, sum_bad;

    uart_rx_byte #(.DIV(DIV)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .frame_err (frame_err),
        .rx_state  (rx_state)
    );

    assign in_frame  = (state != S_SYNC) && (state != S_DONE);
    assign timeout   = in_frame && (idle_cnt == TO_LAST);
    assign abort     = in_frame && (frame_err || timeout);
    assign sync_seen = (state == S_SYNC) && rx_valid && (rx_data == SYNC_BYTE);
    assign sum_bad   = (state == S_SUM) && rx_valid && (rx_data != sum);
    assign fsm_state = state;

    // Loader state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_SYNC;
        else     state <= state_nx;
    end

    // Loader next-state; any framing error or idle timeout mid-frame restarts the hunt for SYNC.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_SYNC:  if (sync_seen) state_nx = S_LEN;
            S_LEN:   if (rx_valid) state_nx = (rx_data == 8'd0) ? S_SUM : S_HI;
            S_HI:    if (rx_valid) state_nx = S_LO;
            S_LO:    if (rx_valid) state_nx = S_WRITE;
            S_WRITE: state_nx = ((word_cnt + 8'd1) == n_len) ? S_SUM : S_HI;
            S_SUM:   if (rx_valid) state_nx = (rx_data == sum) ? S_DONE : S_SYNC;
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_SYNC;
        endcase
        if (abort) state_nx = S_SYNC;
    end

    // Memory port and status decode; S_WRITE lasts one clock so mem_wre is a single pulse.
    always_comb begin
        boot_mode = (state != S_DONE);
        load_done = (state == S_DONE);
        mem_ce    = 1'b1;
        mem_wre   = (state == S_WRITE);
        mem_addr  = {{(ADDR_W - 8){1'b0}}, word_cnt};
        mem_din   = {hi_q, lo_q};
    end

    // Frame datapath: length, checksum, data bytes, word counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_len    <= 8'd0;
            sum      <= 8'd0;
            hi_q     <= 8'd0;
            lo_q     <= 8'd0;
            word_cnt <= 8'd0;
            load_err <= 1'b0;
        end else begin
            if (sync_seen) begin
                load_err <= 1'b0;
                sum      <= 8'd0;
                word_cnt <= 8'd0;
            end
            if (rx_valid) begin
                unique case (state)
                    S_LEN: begin
                        n_len <= rx_data;
                        sum   <= sum_add(sum, rx_data);
                    end
                    S_HI: begin
                        hi_q <= rx_data;
                        sum  <= sum_add(sum, rx_data);
                    end
                    S_LO: begin
                        lo_q <= rx_data;
                        sum  <= sum_add(sum, rx_data);
                    end
                    default: ;
                endcase
            end
            if (state == S_WRITE) word_cnt <= word_cnt + 8'd1;
            if (abort || sum_bad) load_err <= 1'b1;
        end
    end

    // Idle timer: clocks since the last received byte while inside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       idle_cnt <= '0;
        else if (!in_frame || rx_valid) idle_cnt <= '0;
        else if (!timeout)             idle_cnt <= idle_cnt + 1'b1;
    end

endmodule
